// File: rtl/seq_div_if.sv
// Operand and result channels of the sequential divider.
// slave is the divider's view; master is the requester's view.
interface seq_div_if;
    logic        s_axis_dividend_tvalid;
    logic        s_axis_dividend_tready;
    logic [31:0] s_axis_dividend_tdata;
    logic        s_axis_divisor_tvalid;
    logic        s_axis_divisor_tready;
    logic [31:0] s_axis_divisor_tdata;
    logic        m_axis_dout_tvalid;
    logic [63:0] m_axis_dout_tdata;

    modport slave (
        input  s_axis_dividend_tvalid, s_axis_dividend_tdata,
        input  s_axis_divisor_tvalid, s_axis_divisor_tdata,
        output s_axis_dividend_tready, s_axis_divisor_tready,
        output m_axis_dout_tvalid, m_axis_dout_tdata
    );

    modport master (
        output s_axis_dividend_tvalid, s_axis_dividend_tdata,
        output s_axis_divisor_tvalid, s_axis_divisor_tdata,
        input  s_axis_dividend_tready, s_axis_divisor_tready,
        input  m_axis_dout_tvalid, m_axis_dout_tdata
    );
endinterface

// File: rtl/seq_div.sv
// Radix-2 restoring divider, 32 steps per operation, with one-deep operand
// buffers on each input channel. Result is {quotient, remainder}.
module seq_div #(
    parameter bit SIGNED = 1'b0
) (
    input  logic    clk,
    input  logic    resetn,
    seq_div_if.slave bus
);
    typedef enum logic {IDLE, CALC} state_t;

    state_t      state, state_nxt;
    logic        dvd_full, dvs_full;
    logic [31:0] dvd_buf, dvs_buf;
    logic [31:0] rem, quo, dvs_mag, a_raw;
    logic [4:0]  cnt;
    logic        q_neg, r_neg, dz;
    logic        load, done;

    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] sh, diff;
    logic [31:0] rem_nxt, quo_nxt, q_fin, r_fin;

    assign bus.s_axis_dividend_tready = ~dvd_full;
    assign bus.s_axis_divisor_tready  = ~dvs_full;

    assign a_neg = SIGNED && dvd_buf[31];
    assign b_neg = SIGNED && dvs_buf[31];
    assign a_mag = a_neg ? (~dvd_buf + 32'd1) : dvd_buf;
    assign b_mag = b_neg ? (~dvs_buf + 32'd1) : dvs_buf;

    // rem < divisor always holds, so the 33-bit difference has bit 32 set
    // exactly when the trial subtraction borrows.
    always_comb begin
        sh      = {rem, quo[31]};
        diff    = sh - {1'b0, dvs_mag};
        rem_nxt = diff[32] ? sh[31:0] : diff[31:0];
        quo_nxt = {quo[30:0], ~diff[32]};
        if (dz) begin
            q_fin = 32'hFFFF_FFFF;
            r_fin = a_raw;
        end else begin
            q_fin = q_neg ? (~quo_nxt + 32'd1) : quo_nxt;
            r_fin = r_neg ? (~rem_nxt + 32'd1) : rem_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                load = dvd_full && dvs_full;
                if (load) state_nxt = CALC;
            end
            CALC: begin
                done = (cnt == 5'd31);
                if (done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dvd_full <= 1'b0;
            dvs_full <= 1'b0;
            dvd_buf  <= '0;
            dvs_buf  <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs_mag  <= '0;
            a_raw    <= '0;
            cnt      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            dz       <= 1'b0;
            bus.m_axis_dout_tvalid <= 1'b0;
            bus.m_axis_dout_tdata  <= '0;
        end else begin
            // load only fires while both buffers are full, i.e. tready low
            if (bus.s_axis_dividend_tvalid && !dvd_full) begin
                dvd_buf  <= bus.s_axis_dividend_tdata;
                dvd_full <= 1'b1;
            end
            if (bus.s_axis_divisor_tvalid && !dvs_full) begin
                dvs_buf  <= bus.s_axis_divisor_tdata;
                dvs_full <= 1'b1;
            end
            if (load) begin
                dvd_full <= 1'b0;
                dvs_full <= 1'b0;
                rem      <= '0;
                quo      <= a_mag;
                dvs_mag  <= b_mag;
                a_raw    <= dvd_buf;
                q_neg    <= a_neg ^ b_neg;
                r_neg    <= a_neg;
                dz       <= (dvs_buf == 32'd0);
                cnt      <= '0;
            end else if (state == CALC) begin
                rem <= rem_nxt;
                quo <= quo_nxt;
                cnt <= cnt + 5'd1;
            end
            bus.m_axis_dout_tvalid <= done;
            if (done) bus.m_axis_dout_tdata <= {q_fin, r_fin};
        end
    end
endmodule

// File: tb/tb_seq_div.sv
// Directed bench for both divider flavours; a scoreboard queue per instance
// holds the expected result and the edge it must appear after.
module tb_seq_div;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_div_if bu ();
    seq_div_if bs ();

    seq_div #(.SIGNED(1'b0)) du (.clk(clk), .resetn(resetn), .bus(bu));
    seq_div #(.SIGNED(1'b1)) ds (.clk(clk), .resetn(resetn), .bus(bs));

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   last_res[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic bit rdy_a(input bit s);
        return s ? bs.s_axis_dividend_tready : bu.s_axis_dividend_tready;
    endfunction

    function automatic bit rdy_b(input bit s);
        return s ? bs.s_axis_divisor_tready : bu.s_axis_divisor_tready;
    endfunction

    task automatic drv_a(input bit s, input bit v, input logic [31:0] d);
        if (s) begin bs.s_axis_dividend_tvalid = v; bs.s_axis_dividend_tdata = d; end
        else   begin bu.s_axis_dividend_tvalid = v; bu.s_axis_dividend_tdata = d; end
    endtask

    task automatic drv_b(input bit s, input bit v, input logic [31:0] d);
        if (s) begin bs.s_axis_divisor_tvalid = v; bs.s_axis_divisor_tdata = d; end
        else   begin bu.s_axis_divisor_tvalid = v; bu.s_axis_divisor_tdata = d; end
    endtask

    // engine model: load one edge after the pair completes or after the
    // previous result, whichever is later; result 32 edges after load
    task automatic push(input bit s, input logic [63:0] e, input int n);
        exp_t x;
        int ld;
        ld = n + 1;
        if (last_res[s] + 1 > ld) ld = last_res[s] + 1;
        last_res[s] = ld + 32;
        x.data = e;
        x.cyc  = ld + 32;
        if (s) q1.push_back(x);
        else   q0.push_back(x);
    endtask

    task automatic wait_rdy(input bit s);
        int t = 0;
        @(negedge clk);
        while (!(rdy_a(s) && rdy_b(s)) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            checks++; errors++;
            $display("FAIL tready_timeout act=0 exp=1");
        end
    endtask

    task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] e, output int n);
        wait_rdy(s);
        drv_a(s, 1'b1, a);
        drv_b(s, 1'b1, b);
        @(posedge clk);
        #1;
        n = cyc;
        drv_a(s, 1'b0, 32'h0);
        drv_b(s, 1'b0, 32'h0);
        push(s, e, n);
    endtask

    task automatic mon(input bit s, input logic [63:0] d);
        exp_t e;
        if ((s ? q1.size() : q0.size()) == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_result inst=%0d act=%h exp=none", s, d);
        end else begin
            e = s ? q1.pop_front() : q0.pop_front();
            chk($sformatf("result_data inst=%0d", s), d, e.data);
            chk($sformatf("result_edge inst=%0d", s), 64'(cyc), 64'(e.cyc));
        end
    endtask

    always @(negedge clk) begin
        if (bu.m_axis_dout_tvalid) mon(1'b0, bu.m_axis_dout_tdata);
        if (bs.m_axis_dout_tvalid) mon(1'b1, bs.m_axis_dout_tdata);
    end

    task automatic drain();
        int t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            checks++; errors++;
            $display("FAIL drain_timeout act=%0d exp=0", q0.size() + q1.size());
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        last_res[0] = 0;
        last_res[1] = 0;
        drv_a(1'b0, 1'b0, 32'h0); drv_b(1'b0, 1'b0, 32'h0);
        drv_a(1'b1, 1'b0, 32'h0); drv_b(1'b1, 1'b0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid_u", 64'(bu.m_axis_dout_tvalid), 64'd0);
        chk("rst_tdata_u", bu.m_axis_dout_tdata, 64'd0);
        chk("rst_tvalid_s", 64'(bs.m_axis_dout_tvalid), 64'd0);
        chk("rst_tdata_s", bs.m_axis_dout_tdata, 64'd0);
        chk("rst_tready_u", 64'({rdy_a(0), rdy_b(0)}), 64'd3);
        chk("rst_tready_s", 64'({rdy_a(1), rdy_b(1)}), 64'd3);
        resetn = 1'b1;

        // unsigned basic, plus tready low while full and high after load
        issue(1'b0, 32'd100, 32'd7, {32'd14, 32'd2}, n);
        @(negedge clk);
        chk("tready_full", 64'({rdy_a(0), rdy_b(0)}), 64'd0);
        @(negedge clk);
        chk("tready_after_load", 64'({rdy_a(0), rdy_b(0)}), 64'd3);
        drain();

        issue(1'b1, 32'hFFFF_FFF9, 32'd2,          {32'hFFFF_FFFD, 32'hFFFF_FFFF}, n);
        issue(1'b1, 32'd7,          32'hFFFF_FFFE, {32'hFFFF_FFFD, 32'd1}, n);
        issue(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, {32'd3, 32'hFFFF_FFFF}, n);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0}, n);
        issue(1'b1, 32'd5,          32'd0,          {32'hFFFF_FFFF, 32'd5}, n);
        issue(1'b1, 32'hFFFF_FFFB, 32'd0,          {32'hFFFF_FFFF, 32'hFFFF_FFFB}, n);
        issue(1'b0, 32'd5,          32'd0,          {32'hFFFF_FFFF, 32'd5}, n);
        issue(1'b0, 32'hFFFF_FFFF, 32'd1,          {32'hFFFF_FFFF, 32'd0}, n);
        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, n);
        drain();

        // skewed channels; dividend data offered while full must be ignored
        wait_rdy(1'b0);
        drv_a(1'b0, 1'b1, 32'd37);
        @(posedge clk);
        #1;
        drv_a(1'b0, 1'b1, 32'hDEAD_BEEF);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("skew_tready_a k=%0d", k), 64'(rdy_a(0)), 64'd0);
        end
        drv_b(1'b0, 1'b1, 32'd5);
        @(posedge clk);
        #1;
        n = cyc;
        drv_a(1'b0, 1'b0, 32'h0);
        drv_b(1'b0, 1'b0, 32'h0);
        push(1'b0, {32'd7, 32'd2}, n);
        drain();

        // back-to-back: second pair buffered during CALC
        issue(1'b1, 32'd100, 32'hFFFF_FFF9, {32'hFFFF_FFF2, 32'd2}, n);
        @(posedge clk);
        issue(1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFF2, 32'hFFFF_FFFE}, n);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_tready k=%0d", k), 64'({rdy_a(1), rdy_b(1)}), 64'd0);
        end
        drain();

        // reset mid-operation
        issue(1'b0, 32'd1000, 32'd3, {32'd333, 32'd1}, n);
        repeat (9) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        q0.delete();
        last_res[0] = 0;
        chk("midrst_tvalid", 64'(bu.m_axis_dout_tvalid), 64'd0);
        chk("midrst_tready", 64'({rdy_a(0), rdy_b(0)}), 64'd3);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        issue(1'b0, 32'd9, 32'd3, {32'd3, 32'd0}, n);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/seq_div.md
# seq_div

Multi-cycle radix-2 integer divider that accepts dividend and divisor on two independent valid/ready input channels and returns {quotient, remainder} as a one-cycle result pulse. It sits behind the execute-stage ALU as the responder for div.w/mod.w and div.wu/mod.wu. Two instances are used: SIGNED=1 for the signed opcodes and SIGNED=0 for the unsigned ones. Each input channel has a one-deep operand buffer, so the ALU can hand off the next operation while the current one is still computing.

## Interface
- SIGNED, default 0: 1 means two's-complement division; 0 means unsigned.
- clk  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- s_axis_dividend_tvalid  in  1  dividend offered.
- s_axis_dividend_tready  out  1  dividend buffer empty; equals ~dividend_full.
- s_axis_dividend_tdata  in  32  dividend.
- s_axis_divisor_tvalid  in  1  divisor offered.
- s_axis_divisor_tready  out  1  divisor buffer empty; equals ~divisor_full.
- s_axis_divisor_tdata  in  32  divisor.
- m_axis_dout_tvalid  out  1  result valid; one-cycle pulse, no back-pressure.
- m_axis_dout_tdata  out  64  [63:32] quotient, [31:0] remainder; held until the next result.

## Operation
- Operand buffers:
  - A channel handshakes when its tvalid and tready are both high at a rising edge. It captures tdata and sets its full flag.
  - The two channels are independent and may complete on different cycles.
- Engine states:
  - IDLE → CALC when both full flags are set at an edge. On that edge it:
    - loads |dividend| and |divisor| (raw values when SIGNED=0),
    - records the quotient sign (sign(a) ^ sign(b)) and the remainder sign (sign(a)),
    - clears both full flags and sets cnt=0.
  - CALC performs one restoring step per edge: shift {rem, quo} left by 1, then trial-subtract the divisor from rem. If there is no borrow, keep the difference and set quo[0]=1. Then cnt++.
  - On the step with cnt==31, the final quotient and remainder are formed combinationally, including the sign fix-up. m_axis_dout_tdata and m_axis_dout_tvalid=1 are registered, and the engine returns to IDLE.
- m_axis_dout_tvalid deasserts on the next edge unless a new result completes on that edge; in practice it is always deasserted, since the period is at least 33 cycles.
- Arithmetic rules:
  - The quotient truncates toward zero.
  - The remainder carries the sign of the dividend (|rem| < |divisor|).
  - Intermediate rem is 33 bits wide to hold the trial-subtraction borrow.
  - Sign fix-up negates the quotient and/or remainder in 32-bit two's complement.
- Divide by zero, both SIGNED settings: quotient = 0xFFFFFFFF, remainder = the original dividend (unnegated), with no sign fix-up.
- Signed overflow, 0x80000000 / 0xFFFFFFFF with SIGNED=1: quotient 0x80000000, remainder 0 (natural wrap).

## Timing
- Reset values (asynchronous, held while resetn=0):
  - m_axis_dout_tvalid=0, m_axis_dout_tdata=0.
  - Both full flags 0, so both treadys read 1.
  - State IDLE, cnt=0.
- Reset mid-CALC abandons the operation and any buffered operands. No result pulse follows.
- Latency: if the second handshake of a pair completes at edge n with the engine IDLE, then:
  - the load happens at edge n+1,
  - iterations run on edges n+2..n+33,
  - m_axis_dout_tvalid is high between edges n+33 and n+34.
- Buffered operands while the engine is busy:
  - New operands may be accepted during CALC, since tready is high after the load clears the full flag.
  - The load occurs at the edge after the final CALC step, i.e. the edge where tvalid falls. Back-to-back period is 33 cycles.
- Simultaneous events:
  - A handshake on one channel and the load on the same edge cannot collide, because tready is low while full.
  - A handshake on the edge that the load clears full is impossible for the same reason. The buffer refills no earlier than the following edge.
- tdata on the input channels is ignored when tready is low. tvalid may drop without a handshake; no transaction occurs.
- No m_axis tready: a result not sampled during its pulse is lost from tvalid, but tdata remains readable.

## Test plan
- Unsigned basic: SIGNED=0, 100/7 with both handshakes at edge n → tvalid only in cycle n+33..n+34, tdata = {32'd14, 32'd2}. Both treadys are 1 again from edge n+1.
- Signed sign rules: SIGNED=1, -7/2 → {0xFFFFFFFD, 0xFFFFFFFF}. 7/-2 → {0xFFFFFFFD, 1}. -7/-2 → {3, 0xFFFFFFFF}.
- Corner values:
  - 0x80000000/0xFFFFFFFF with SIGNED=1 → {0x80000000, 0}.
  - 5/0 with SIGNED=0 and with SIGNED=1 → {0xFFFFFFFF, 5}.
  - 0xFFFFFFFF/1 with SIGNED=0 → {0xFFFFFFFF, 0}.
- Skewed channels: dividend handshake at edge 10, divisor at edge 15 → load at 16, tvalid between edges 48 and 49. dividend_tready stays 0 during edges 11..15.
- Back-to-back buffering: a second pair is accepted at edge n+3 during CALC → second load at n+34, second tvalid between n+66 and n+67. Both results are correct, and tready is 0 while the buffers are full.
- Reset mid-operation: drop resetn at n+10 for 2 cycles → tvalid=0 and tready=1 immediately. No stale pulse appears afterwards, and a fresh 9/3 returns {3, 0} with standard latency.
